// File: rtl/finn_input_packer.sv
// rtl/finn_input_packer.sv - byte-to-word AXI-Stream packer feeding the finn_design s_axis_0 input
// Optional partial-word timeout flush is enabled by defining FINN_PACK_TIMEOUT_EN.
module finn_input_packer #(
  parameter int IN_W        = 8,
  parameter int BYTES       = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [IN_W-1:0]       s_axis_byte_tdata,
  input  logic                  s_axis_byte_tvalid,
  output logic                  s_axis_byte_tready,
  output logic [IN_W*BYTES-1:0] m_axis_0_tdata,
  output logic                  m_axis_0_tvalid,
  input  logic                  m_axis_0_tready,
  output logic [31:0]           word_count
);

  localparam int OUT_W = IN_W * BYTES;
  localparam int ACC_W = OUT_W - IN_W;
  localparam int IDX_W = $clog2(BYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES - 1);

  if (BYTES < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("finn_input_packer: BYTES must be >= 2 and TIMEOUT_CYC >= 1");
  end

  // The final byte goes straight into the output register, so only the lower bytes are held here.
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             byte_xfer;
  logic             word_xfer;

`ifdef FINN_PACK_TIMEOUT_EN
  typedef enum logic [0:0] {FILL = 1'b0, FLUSH = 1'b1} state_e;
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);

  state_e            state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [ACC_W-1:0]  pad;
`endif

  always_comb begin
    s_axis_byte_tready = !(idx_q == LAST && vld_q && !m_axis_0_tready);
`ifdef FINN_PACK_TIMEOUT_EN
    if (state_q != FILL) s_axis_byte_tready = 1'b0;
`endif
  end

  assign byte_xfer = s_axis_byte_tvalid && s_axis_byte_tready;
  assign word_xfer = vld_q && m_axis_0_tready;

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    out_d = out_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
`ifdef FINN_PACK_TIMEOUT_EN
    state_d = state_q;
    idle_d  = idle_q;
    pad     = '0;
`endif

    // Drain first so a same-cycle completing byte (or flush) can re-set valid without a bubble.
    if (word_xfer) begin
      vld_d = 1'b0;
      cnt_d = cnt_q + 32'd1;
    end

    if (byte_xfer) begin
      if (idx_q == LAST) begin
        out_d = {s_axis_byte_tdata, acc_q};
        vld_d = 1'b1;
        idx_d = '0;
      end else begin
        acc_d[int'(idx_q)*IN_W +: IN_W] = s_axis_byte_tdata;
        idx_d = idx_q + IDX_W'(1);
      end
    end

`ifdef FINN_PACK_TIMEOUT_EN
    case (state_q)
      FILL: begin
        if (byte_xfer || idx_q == '0) begin
          idle_d = '0;
        end else if (idle_q == IDLE_MAX) begin
          state_d = FLUSH;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      default: begin
        if (!vld_q || m_axis_0_tready) begin
          for (int i = 0; i < BYTES - 1; i++) begin
            if (i < int'(idx_q)) pad[i*IN_W +: IN_W] = acc_q[i*IN_W +: IN_W];
          end
          out_d   = {{IN_W{1'b0}}, pad};
          vld_d   = 1'b1;
          idx_d   = '0;
          idle_d  = '0;
          state_d = FILL;
        end
      end
    endcase
`endif
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q <= '0;
      idx_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      out_q <= out_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef FINN_PACK_TIMEOUT_EN
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= FILL;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
    end
  end
`endif

  assign m_axis_0_tdata  = out_q;
  assign m_axis_0_tvalid = vld_q;
  assign word_count      = cnt_q;

endmodule

// File: tb/tb_finn_input_packer.sv
// tb/tb_finn_input_packer.sv - directed self-checking bench for finn_input_packer
module tb_finn_input_packer;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [39:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [31:0] word_count;

  int checks = 0;
  int errors = 0;

  logic [39:0] words[$];
  int          word_cyc[$];
  int          cyc = 0;
  int          vld_cycles = 0;

  finn_input_packer #(.IN_W(8), .BYTES(5), .TIMEOUT_CYC(16)) dut (
    .ap_clk             (ap_clk),
    .ap_rst             (ap_rst),
    .s_axis_byte_tdata  (s_tdata),
    .s_axis_byte_tvalid (s_tvalid),
    .s_axis_byte_tready (s_tready),
    .m_axis_0_tdata     (m_tdata),
    .m_axis_0_tvalid    (m_tvalid),
    .m_axis_0_tready    (m_tready),
    .word_count         (word_count)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Record words that will transfer on the coming rising edge.
  always @(negedge ap_clk) begin
    #2;
    if (!ap_rst && m_tvalid) begin
      vld_cycles++;
      if (m_tready) begin
        words.push_back(m_tdata);
        word_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_log();
    words.delete();
    word_cyc.delete();
    vld_cycles = 0;
  endtask

  task automatic do_reset();
    ap_rst   = 1'b1;
    s_tvalid = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    s_tdata  = b;
    s_tvalid = 1'b1;
    #1;
    guard = 0;
    while (!s_tready && guard < 50) begin
      @(negedge ap_clk);
      #1;
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL send_byte_timeout: byte %02h not accepted, tready=%b required 1", b, s_tready);
    end
    @(negedge ap_clk);
    s_tvalid = 1'b0;
  endtask

  function automatic logic [39:0] first_word();
    return (words.size() > 0) ? words[0] : 40'hxx_xxxx_xxxx;
  endfunction

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (2) @(negedge ap_clk);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", m_tvalid); end
    checks++; if (m_tdata !== 40'h0) begin errors++; $display("FAIL reset_tdata: got %h required 0", m_tdata); end
    checks++; if (word_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d required 0", word_count); end
    ap_rst = 1'b0;
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b required 1", s_tready); end
    @(negedge ap_clk);
    clear_log();
  endtask

  task automatic test_basic();
    do_reset();
    m_tready = 1'b1;
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    repeat (3) @(negedge ap_clk);
    checks++; if (words.size() !== 1) begin errors++; $display("FAIL basic_nwords: got %0d required 1", words.size()); end
    checks++; if (first_word() !== 40'h0504030201) begin errors++; $display("FAIL basic_word: got %h required 0504030201", first_word()); end
    checks++; if (vld_cycles !== 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d required 1", vld_cycles); end
    checks++; if (word_count !== 32'd1) begin errors++; $display("FAIL basic_count: got %0d required 1", word_count); end
  endtask

  task automatic test_backpressure();
    logic [39:0] w;
    do_reset();
    m_tready = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 40'h0504030201) begin errors++; $display("FAIL bp_word1: got v=%b %h required v=1 0504030201", m_tvalid, m_tdata); end
    for (int i = 6; i <= 9; i++) send_byte(8'(i));
    s_tdata  = 8'h0A;
    s_tvalid = 1'b1;
    #1;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_stall: tready got %b required 0", s_tready); end
    repeat (3) @(negedge ap_clk);
    #1;
    checks++; if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 40'h0504030201) begin
      errors++; $display("FAIL bp_hold: got rdy=%b v=%b %h required rdy=0 v=1 0504030201", s_tready, m_tvalid, m_tdata);
    end
    m_tready = 1'b1;
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL bp_release: tready got %b required 1", s_tready); end
    @(negedge ap_clk);
    s_tvalid = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 40'h0A09080706) begin errors++; $display("FAIL bp_reload: got v=%b %h required v=1 0A09080706", m_tvalid, m_tdata); end
    repeat (2) @(negedge ap_clk);
    checks++; if (words.size() !== 2) begin errors++; $display("FAIL bp_nwords: got %0d required 2", words.size()); end
    w = (words.size() > 1) ? words[1] : 40'hxx_xxxx_xxxx;
    checks++; if (first_word() !== 40'h0504030201 || w !== 40'h0A09080706) begin errors++; $display("FAIL bp_order: got %h %h required 0504030201 0A09080706", first_word(), w); end
    checks++; if (words.size() == 2 && word_cyc[1] - word_cyc[0] !== 1) begin errors++; $display("FAIL bp_b2b: gap got %0d required 1", word_cyc[1] - word_cyc[0]); end
    checks++; if (word_count !== 32'd2) begin errors++; $display("FAIL bp_count: got %0d required 2", word_count); end
  endtask

  task automatic test_streaming();
    int stalls;
    logic [39:0] exp;
    do_reset();
    m_tready = 1'b1;
    stalls   = 0;
    for (int i = 0; i < 50; i++) begin
      s_tdata  = 8'(i);
      s_tvalid = 1'b1;
      #1;
      if (!s_tready) stalls++;
      @(negedge ap_clk);
    end
    s_tvalid = 1'b0;
    repeat (3) @(negedge ap_clk);
    checks++; if (stalls !== 0) begin errors++; $display("FAIL stream_ready: stalls got %0d required 0", stalls); end
    checks++; if (words.size() !== 10) begin errors++; $display("FAIL stream_nwords: got %0d required 10", words.size()); end
    for (int k = 0; k < words.size(); k++) begin
      for (int j = 0; j < 5; j++) exp[8*j +: 8] = 8'(5*k + j);
      checks++; if (words[k] !== exp) begin errors++; $display("FAIL stream_word%0d: got %h required %h", k, words[k], exp); end
      if (k > 0) begin
        checks++; if (word_cyc[k] - word_cyc[k-1] !== 5) begin errors++; $display("FAIL stream_gap%0d: got %0d required 5", k, word_cyc[k] - word_cyc[k-1]); end
      end
    end
    checks++; if (word_count !== 32'd10) begin errors++; $display("FAIL stream_count: got %0d required 10", word_count); end
  endtask

  task automatic test_reset_midword();
    do_reset();
    m_tready = 1'b1;
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    ap_rst = 1'b1;
    repeat (2) @(negedge ap_clk);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b required 0", m_tvalid); end
    ap_rst = 1'b0;
    clear_log();
    for (int i = 8'h11; i <= 8'h15; i++) send_byte(8'(i));
    repeat (3) @(negedge ap_clk);
    checks++; if (words.size() !== 1) begin errors++; $display("FAIL midrst_nwords: got %0d required 1", words.size()); end
    checks++; if (first_word() !== 40'h1514131211) begin errors++; $display("FAIL midrst_word: got %h required 1514131211", first_word()); end
    checks++; if (word_count !== 32'd1) begin errors++; $display("FAIL midrst_count: got %0d required 1", word_count); end
  endtask

  task automatic test_timeout();
    do_reset();
    m_tready = 1'b1;
    send_byte(8'hAA);
    send_byte(8'hBB);
`ifdef FINN_PACK_TIMEOUT_EN
    repeat (40) @(negedge ap_clk);
    checks++; if (words.size() !== 1) begin errors++; $display("FAIL timeout_nwords: got %0d required 1", words.size()); end
    checks++; if (first_word() !== 40'h000000BBAA) begin errors++; $display("FAIL timeout_word: got %h required 000000BBAA", first_word()); end
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL timeout_tready: got %b required 1", s_tready); end
`else
    repeat (100) @(negedge ap_clk);
    checks++; if (words.size() !== 0) begin errors++; $display("FAIL notimeout_nwords: got %0d required 0", words.size()); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL notimeout_tvalid: got %b required 0", m_tvalid); end
    for (int i = 8'h03; i <= 8'h05; i++) send_byte(8'(i));
    repeat (3) @(negedge ap_clk);
    checks++; if (first_word() !== 40'h050403BBAA) begin errors++; $display("FAIL notimeout_resume: got %h required 050403BBAA", first_word()); end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    m_tready = 1'b1;
    force dut.cnt_q = 32'hFFFF_FFFF;
    @(negedge ap_clk);
    release dut.cnt_q;
    @(negedge ap_clk);
    checks++; if (word_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preset: got %h required ffffffff", word_count); end
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    repeat (3) @(negedge ap_clk);
    checks++; if (word_count !== 32'h0) begin errors++; $display("FAIL wrap_count: got %h required 00000000", word_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_streaming();
    test_reset_midword();
    test_timeout();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
